regfile_dump_ctrl: RTL and testbench
====================================

Name: regfile_dump_ctrl

Overview:
Debug sequencer that streams the full MIPS register file out to the debug UART transmitter. On a start request it halts the pipeline and waits for drain acknowledge. It then walks register indices 0..LENGTH-1 through the register file's registered read port 1 and sends each word as WIDTH/8 bytes, MSB first, over a valid/ready byte interface. It sits between the debug unit (start/done), the pipeline stall logic (halt_req/halt_ack), the register file read port, and the UART TX.

Parameters:
WIDTH, 32, register width in bits; must be a multiple of 8
LENGTH, 32, number of registers to dump
NB, $clog2(LENGTH), register index width
NBYTES, WIDTH/8, bytes per register (derived, not overridden)

Ports:
clk  in  1  clock, rising-edge
reset  in  1  synchronous, active-high
start  in  1  dump request, sampled only in IDLE
halt_ack  in  1  pipeline drained/frozen; no register file writes while high
rf_rd_data  in  WIDTH  register file read_data_1; registered, valid 1 cycle after rf_rd_addr is presented
tx_ready  in  1  UART TX accepts byte this cycle
halt_req  out  1  request pipeline freeze
rf_rd_addr  out  NB  drives register file read_register_1
tx_data  out  8  byte to transmit
tx_valid  out  1  tx_data valid
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of dump

Behaviour:
- Reset is synchronous and active-high; clock is clk. At reset, state=IDLE and all outputs are 0: halt_req, rf_rd_addr, tx_data, tx_valid, busy, done. Internal byte counter and shift register are cleared.
- Reset mid-dump aborts immediately: the next cycle shows IDLE outputs, and no done pulse is produced.
- FSM states: IDLE, HALT, ADDR, WAIT, SEND, DONE.
- IDLE: if start=1, go to HALT. start in any other state is ignored; it is not queued.
- HALT: halt_req=1, held from this state through DONE inclusive. When halt_ack=1, set rf_rd_addr=0 and go to ADDR.
- ADDR: rf_rd_addr is stable. The register file samples it at this clock edge. Go to WAIT.
- WAIT: rf_rd_data is valid. Load the shift register with rf_rd_data, set byte_cnt=0, go to SEND.
- SEND:
  - tx_valid=1 and tx_data = shift_reg[WIDTH-1:WIDTH-8].
  - tx_data must stay stable while tx_valid=1 and tx_ready=0.
  - A byte transfers on a cycle where tx_valid=1 and tx_ready=1.
  - On transfer with byte_cnt<NBYTES-1: shift left by 8, increment byte_cnt, stay in SEND. tx_valid stays high with no bubble.
  - On transfer of the last byte with rf_rd_addr<LENGTH-1: increment rf_rd_addr, drop tx_valid, go to ADDR.
  - On transfer of the last byte with rf_rd_addr=LENGTH-1: go to DONE.
- DONE: done=1 for exactly one cycle. halt_req drops on the DONE->IDLE edge. rf_rd_addr returns to 0. Go to IDLE.
- halt_ack dropping while in ADDR/WAIT/SEND is ignored; the dump completes.
- Total bytes per dump = LENGTH*NBYTES (128 at defaults). Order is register 0 first, MSB byte first.
- Minimum latency with tx_ready tied 1 and halt_ack tied 1, from the start cycle to the done pulse: 1 (HALT) + LENGTH*(2+NBYTES) + 1 cycles = 194 at defaults.
- No arithmetic wrap: rf_rd_addr never exceeds LENGTH-1.

Test Plan:
- Regfile model holds reg k = 32'hA500_0000 | k. Pulse start, halt_ack=1 after 3 cycles, tx_ready=1 -> exactly 128 bytes: A5 00 00 00, A5 00 00 01, …, A5 00 00 1F. One done pulse. busy high from the cycle after start until after done.
- Same setup with tx_ready toggling 1-of-3 cycles -> identical byte stream. tx_data stable whenever tx_valid=1 and tx_ready=0. No byte dropped or duplicated.
- start=1 with halt_ack held 0 for 50 cycles -> halt_req=1, tx_valid=0, rf_rd_addr=0 throughout. Raising halt_ack -> dump proceeds normally.
- Assert reset during SEND of register 5, byte 2 -> next cycle all outputs 0 and no done pulse. A fresh start then dumps from register 0.
- Pulse start again during SEND -> ignored: byte count stays 128 and only one done pulse.
- tx_ready=1, halt_ack=1 continuously -> done asserted exactly 194 cycles after the start cycle.

Source files
------------

// File: rtl/regfile_dump_ctrl.sv
// regfile_dump_ctrl: debug sequencer that freezes the pipeline, walks the
// register file through its registered read port and streams every word
// out as bytes (MSB first) over a valid/ready byte interface.
module regfile_dump_ctrl #(
  parameter  int WIDTH  = 32,
  parameter  int LENGTH = 32,
  parameter  int NB     = $clog2(LENGTH),
  localparam int NBYTES = WIDTH / 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             halt_ack,
  input  logic [WIDTH-1:0] rf_rd_data,
  input  logic             tx_ready,
  output logic             halt_req,
  output logic [NB-1:0]    rf_rd_addr,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  output logic             busy,
  output logic             done
);

  localparam int BCW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HALT = 3'd1,
    ADDR = 3'd2,
    WAIT = 3'd3,
    SEND = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shift_reg;
  logic [BCW-1:0]   byte_cnt;

  // The outgoing byte is always the top of the shift register; shifting on
  // every accepted byte leaves it zero once a word has been fully sent.
  assign tx_data = shift_reg[WIDTH-1 -: 8];

  // Sequencer: all outputs are registered and change on state transitions.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      halt_req   <= 1'b0;
      rf_rd_addr <= '0;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      byte_cnt   <= '0;
      shift_reg  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= HALT;
            halt_req <= 1'b1;
            busy     <= 1'b1;
          end
        end
        HALT: begin
          if (halt_ack) begin
            rf_rd_addr <= '0;
            state      <= ADDR;
          end
        end
        // Register file captures rf_rd_addr at the end of this cycle.
        ADDR: state <= WAIT;
        WAIT: begin
          shift_reg <= rf_rd_data;
          byte_cnt  <= '0;
          tx_valid  <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          // Nothing moves while the UART stalls, so tx_data holds steady.
          if (tx_ready) begin
            shift_reg <= shift_reg << 8;
            if (byte_cnt != BCW'(NBYTES - 1)) begin
              byte_cnt <= byte_cnt + BCW'(1);
            end else begin
              tx_valid <= 1'b0;
              if (rf_rd_addr != NB'(LENGTH - 1)) begin
                rf_rd_addr <= rf_rd_addr + NB'(1);
                state      <= ADDR;
              end else begin
                done  <= 1'b1;
                state <= DONE;
              end
            end
          end
        end
        DONE: begin
          halt_req   <= 1'b0;
          busy       <= 1'b0;
          rf_rd_addr <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// tb_regfile_dump_ctrl: table of dump scenarios (halt_ack delay, UART
// ready pattern, stray start) plus a hand-written reset-mid-dump sequence.
module tb_regfile_dump_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, halt_ack, tx_ready;
  logic [31:0] rf_rd_data;
  logic        halt_req, tx_valid, busy, done;
  logic [4:0]  rf_rd_addr;
  logic [7:0]  tx_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int ack_delay;    // iteration at which halt_ack rises
    int ready_period; // tx_ready high when iteration % period == 0
    bit start_mid;    // extra start pulse during SEND
    int exp_bytes;
    int exp_dones;
    int exp_latency;  // start iteration to done iteration, -1 = unchecked
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  regfile_dump_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .halt_ack(halt_ack),
    .rf_rd_data(rf_rd_data), .tx_ready(tx_ready), .halt_req(halt_req),
    .rf_rd_addr(rf_rd_addr), .tx_data(tx_data), .tx_valid(tx_valid),
    .busy(busy), .done(done)
  );

  // Register file model: registered read port, reg k = A500_00kk.
  always @(posedge clk) rf_rd_data <= 32'hA500_0000 | {27'd0, rf_rd_addr};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_dump(input vec_t v, input int idx);
    logic [7:0]  q[$];
    logic [7:0]  prev_data = 8'h00;
    logic [31:0] word;
    bit          prev_stall = 1'b0;
    bit          exp_busy;
    int          done_k = -1, ndone = 0, mism = 0;
    int          stable_bad = 0, halt_bad = 0, busy_bad = 0;
    int          k;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      start    = (k == 0) || (v.start_mid && k == 100);
      halt_ack = (k >= v.ack_delay);
      tx_ready = (k % v.ready_period == 0);
      if (prev_stall && (!tx_valid || tx_data !== prev_data)) stable_bad++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (tx_valid && tx_ready) q.push_back(tx_data);
      if (k >= 1 && k <= v.ack_delay && (!halt_req || tx_valid || rf_rd_addr != 5'd0)) halt_bad++;
      exp_busy = (k >= 1) && (done_k < 0);
      if (busy !== exp_busy || halt_req !== exp_busy) busy_bad++;
      if (done === 1'b1) begin
        ndone++;
        if (done_k < 0) done_k = k;
      end
      if (done_k >= 0 && k >= done_k + 3) break;
    end
    start = 1'b0; halt_ack = 1'b0; tx_ready = 1'b0;
    for (int i = 0; i < q.size() && i < 128; i++) begin
      word = 32'hA500_0000 | (i / 4);
      if (q[i] !== word[31 - 8*(i % 4) -: 8]) mism++;
    end
    $display("vector %0d: bytes=%0d dones=%0d done_at=%0d", idx, q.size(), ndone, done_k);
    chk($sformatf("v%0d_finished", idx), done_k >= 0, 1);
    chk($sformatf("v%0d_byte_count", idx), q.size(), v.exp_bytes);
    chk($sformatf("v%0d_stream_mism", idx), mism, 0);
    chk($sformatf("v%0d_done_pulses", idx), ndone, v.exp_dones);
    chk($sformatf("v%0d_stable_bad", idx), stable_bad, 0);
    chk($sformatf("v%0d_halt_wait_bad", idx), halt_bad, 0);
    chk($sformatf("v%0d_busy_bad", idx), busy_bad, 0);
    if (v.exp_latency >= 0) chk($sformatf("v%0d_latency", idx), done_k, v.exp_latency);
    chk($sformatf("v%0d_idle_addr", idx), rf_rd_addr, 0);
    chk($sformatf("v%0d_idle_valid", idx), tx_valid, 0);
    chk($sformatf("v%0d_idle_data", idx), tx_data, 0);
  endtask

  initial begin
    int done_seen;
    vecs[0] = '{ack_delay: 0,  ready_period: 1, start_mid: 0, exp_bytes: 128, exp_dones: 1, exp_latency: 194};
    vecs[1] = '{ack_delay: 3,  ready_period: 1, start_mid: 0, exp_bytes: 128, exp_dones: 1, exp_latency: 196};
    vecs[2] = '{ack_delay: 3,  ready_period: 3, start_mid: 0, exp_bytes: 128, exp_dones: 1, exp_latency: -1};
    vecs[3] = '{ack_delay: 50, ready_period: 1, start_mid: 0, exp_bytes: 128, exp_dones: 1, exp_latency: 243};
    vecs[4] = '{ack_delay: 0,  ready_period: 1, start_mid: 1, exp_bytes: 128, exp_dones: 1, exp_latency: 194};
    vecs[5] = '{ack_delay: 1,  ready_period: 2, start_mid: 0, exp_bytes: 128, exp_dones: 1, exp_latency: -1};

    reset = 1'b1; start = 1'b0; halt_ack = 1'b0; tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_halt_req", halt_req, 0);
    chk("rst_addr", rf_rd_addr, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_dump(vecs[i], i);

    // Reset while sending register 5, byte 2 (iteration 36 at full speed).
    for (int k = 0; k <= 36; k++) begin
      @(negedge clk);
      start = (k == 0); halt_ack = 1'b1; tx_ready = 1'b1;
    end
    chk("mid_addr", rf_rd_addr, 5);
    chk("mid_valid", tx_valid, 1);
    chk("mid_data", tx_data, 8'h00);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; halt_ack = 1'b0; tx_ready = 1'b0;
    chk("abort_halt_req", halt_req, 0);
    chk("abort_addr", rf_rd_addr, 0);
    chk("abort_tx_data", tx_data, 0);
    chk("abort_tx_valid", tx_valid, 0);
    chk("abort_busy", busy, 0);
    done_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    chk("abort_no_done", done_seen, 0);
    run_dump(vecs[0], 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
